// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_lock_supervisor_pkg;

  // Per-channel sequencer states.
  typedef enum logic [2:0] {
    StPwrdwn   = 3'd0,
    StReset    = 3'd1,
    StWaitLock = 3'd2,
    StStable   = 3'd3,
    StLocked   = 3'd4,
    StFail     = 3'd5
  } ch_state_e;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) bits = i + 1;
    end
    return bits;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_ch.sv
// One supervised PLL: LOCKED synchroniser, bring-up sequencer, retry and lock-loss counters.
module pll_lock_supervisor_ch
  import pll_lock_supervisor_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             locked_i,
  input  logic             pwrdwn_i,
  input  logic             restart_i,
  output logic             pll_rst_o,
  output logic             pll_pwrdwn_o,
  output logic             ready_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] loss_cnt_o
);

  localparam int unsigned TimerW = clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES));
  localparam int unsigned RetryW = clog2(MAX_RETRIES + 1);

  localparam logic [TimerW-1:0] RstLast    = TimerW'(RST_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLast   = TimerW'(LOCK_TIMEOUT - 1);
  localparam logic [TimerW-1:0] StableLast = TimerW'(STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax   = RetryW'(MAX_RETRIES);
  localparam logic [CNT_W-1:0]  LossMax    = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  ch_state_e         state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [CNT_W-1:0]  loss_q, loss_d;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // LOCKED is asynchronous to clk_i; shift it through a plain flop chain.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_i};
    end
  end

  // Next-state: power-down beats restart, restart beats the sequencer.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (pwrdwn_i) begin
      state_d = StPwrdwn;
      timer_d = '0;
      retry_d = '0;
    end else if (restart_i && (state_q != StPwrdwn)) begin
      state_d = StReset;
      timer_d = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StPwrdwn: begin
          state_d = StReset;
          timer_d = '0;
          retry_d = '0;
        end
        StReset: begin
          if (timer_q == RstLast) begin
            state_d = StWaitLock;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StWaitLock: begin
          if (locked_s) begin
            state_d = StStable;
            timer_d = '0;
          end else if (timer_q == LockLast) begin
            timer_d = '0;
            if (retry_q < RetryMax) begin
              retry_d = retry_q + 1'b1;
              state_d = StReset;
            end else begin
              state_d = StFail;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StStable: begin
          // A single low sample restarts qualification without burning a retry.
          if (!locked_s) begin
            state_d = StWaitLock;
            timer_d = '0;
          end else if (timer_q == StableLast) begin
            state_d = StLocked;
            timer_d = '0;
            retry_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StLocked: begin
          if (!locked_s) begin
            state_d = StReset;
            timer_d = '0;
            if (loss_q != LossMax) loss_d = loss_q + 1'b1;
          end
        end
        StFail: begin
          state_d = StFail;
        end
        default: begin
          state_d = StReset;
          timer_d = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Sequencer registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StReset;
      timer_q <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    pll_rst_o    = (state_q == StPwrdwn) || (state_q == StReset) || (state_q == StFail);
    pll_pwrdwn_o = (state_q == StPwrdwn);
    ready_o      = (state_q == StLocked);
    fail_o       = (state_q == StFail);
    loss_cnt_o   = loss_q;
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Bring-up and lock supervisor for NUM_CH independent PLLs.
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_CH-1:0]       I_LOCKED,
  input  logic [NUM_CH-1:0]       I_PWRDWN,
  input  logic [NUM_CH-1:0]       I_RESTART,
  output logic [NUM_CH-1:0]       O_PLL_RST,
  output logic [NUM_CH-1:0]       O_PLL_PWRDWN,
  output logic [NUM_CH-1:0]       O_READY,
  output logic [NUM_CH-1:0]       O_FAIL,
  output logic                    O_ALL_READY,
  output logic [NUM_CH*CNT_W-1:0] O_LOSS_CNT
);

  // One fully independent sequencer per PLL.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pll_lock_supervisor_ch #(
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .MAX_RETRIES  (MAX_RETRIES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk_i       (CLK),
      .rst_ni      (RST),
      .locked_i    (I_LOCKED[i]),
      .pwrdwn_i    (I_PWRDWN[i]),
      .restart_i   (I_RESTART[i]),
      .pll_rst_o   (O_PLL_RST[i]),
      .pll_pwrdwn_o(O_PLL_PWRDWN[i]),
      .ready_o     (O_READY[i]),
      .fail_o      (O_FAIL[i]),
      .loss_cnt_o  (O_LOSS_CNT[i*CNT_W +: CNT_W])
    );
  end

  // Aggregate readiness, derived from registered per-channel state.
  always_comb begin
    O_ALL_READY = &O_READY;
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed plus randomized bench for pll_lock_supervisor with a phase/countdown reference model.
module tb_pll_lock_supervisor;

  localparam int unsigned NCH  = 2;
  localparam int unsigned RSTC = 4;
  localparam int unsigned LT   = 16;
  localparam int unsigned MAXR = 2;
  localparam int unsigned STBL = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned CW   = 2;

  // Reference-model phases.
  localparam int POff = 0, PRst = 1, PWait = 2, PQual = 3, PUp = 4, PDead = 5;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NCH-1:0]    I_LOCKED, I_PWRDWN, I_RESTART;
  logic [NCH-1:0]    O_PLL_RST, O_PLL_PWRDWN, O_READY, O_FAIL;
  logic              O_ALL_READY;
  logic [NCH*CW-1:0] O_LOSS_CNT;

  always #5 CLK = ~CLK;

  pll_lock_supervisor #(
    .NUM_CH       (NCH),
    .RST_CYCLES   (RSTC),
    .LOCK_TIMEOUT (LT),
    .MAX_RETRIES  (MAXR),
    .STABLE_CYCLES(STBL),
    .SYNC_STAGES  (SYNC),
    .CNT_W        (CW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .I_LOCKED    (I_LOCKED),
    .I_PWRDWN    (I_PWRDWN),
    .I_RESTART   (I_RESTART),
    .O_PLL_RST   (O_PLL_RST),
    .O_PLL_PWRDWN(O_PLL_PWRDWN),
    .O_READY     (O_READY),
    .O_FAIL      (O_FAIL),
    .O_ALL_READY (O_ALL_READY),
    .O_LOSS_CNT  (O_LOSS_CNT)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: phase, cycles left in phase, attempt number, loss count, LOCKED delay line.
  int             ph[NCH];
  int             left[NCH];
  int             att[NCH];
  int             loss[NCH];
  logic [NCH-1:0] hist[$];

  // PLL emulation driving I_LOCKED.
  bit pll_ok[NCH];
  int delay[NCH];
  int since[NCH];
  bit drop[NCH];

  logic           rst_n_drv;
  logic [NCH-1:0] pd, rs;

  function automatic bit m_rst(input int c);
    return (ph[c] == POff) || (ph[c] == PRst) || (ph[c] == PDead);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic enter_reset(input int c);
    ph[c]   = PRst;
    left[c] = RSTC;
    att[c]  = 1;
  endtask

  task automatic model_step();
    logic [NCH-1:0] ls;
    if (!RST) begin
      for (int c = 0; c < NCH; c++) begin
        enter_reset(c);
        loss[c] = 0;
      end
      hist.delete();
      repeat (SYNC) hist.push_back('0);
    end else begin
      ls = hist.pop_front();
      hist.push_back(I_LOCKED);
      for (int c = 0; c < NCH; c++) begin
        if (I_PWRDWN[c]) begin
          ph[c] = POff;
        end else if (I_RESTART[c] && ph[c] != POff) begin
          enter_reset(c);
        end else begin
          case (ph[c])
            POff: enter_reset(c);
            PRst: begin
              left[c]--;
              if (left[c] == 0) begin
                ph[c] = PWait;
                left[c] = LT;
              end
            end
            PWait: begin
              if (ls[c]) begin
                ph[c] = PQual;
                left[c] = STBL;
              end else begin
                left[c]--;
                if (left[c] == 0) begin
                  if (att[c] <= MAXR) begin
                    att[c]++;
                    ph[c] = PRst;
                    left[c] = RSTC;
                  end else begin
                    ph[c] = PDead;
                  end
                end
              end
            end
            PQual: begin
              if (!ls[c]) begin
                ph[c] = PWait;
                left[c] = LT;
              end else begin
                left[c]--;
                if (left[c] == 0) begin
                  ph[c] = PUp;
                  att[c] = 1;
                end
              end
            end
            PUp: begin
              if (!ls[c]) begin
                enter_reset(c);
                if (loss[c] < (1 << CW) - 1) loss[c]++;
              end
            end
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0]    er, ep, ey, ef;
    logic [NCH*CW-1:0] el;
    er = '0; ep = '0; ey = '0; ef = '0; el = '0;
    for (int c = 0; c < NCH; c++) begin
      er[c] = m_rst(c);
      ep[c] = (ph[c] == POff);
      ey[c] = (ph[c] == PUp);
      ef[c] = (ph[c] == PDead);
      el[c*CW +: CW] = CW'(loss[c]);
    end
    chk("pll_rst", 32'(O_PLL_RST), 32'(er));
    chk("pll_pwrdwn", 32'(O_PLL_PWRDWN), 32'(ep));
    chk("ready", 32'(O_READY), 32'(ey));
    chk("fail", 32'(O_FAIL), 32'(ef));
    chk("all_ready", 32'(O_ALL_READY), 32'(&ey));
    chk("loss_cnt", 32'(O_LOSS_CNT), 32'(el));
  endtask

  // Drive at the falling edge, step the model on the rising edge, compare at the next falling edge.
  task automatic cycle();
    for (int c = 0; c < NCH; c++) begin
      if (m_rst(c)) since[c] = 0;
      else since[c]++;
      I_LOCKED[c] = pll_ok[c] && (since[c] >= delay[c]) && !drop[c];
    end
    RST       = rst_n_drv;
    I_PWRDWN  = pd;
    I_RESTART = rs;
    @(posedge CLK);
    model_step();
    cyc++;
    @(negedge CLK);
    check_all();
    rs = '0;
  endtask

  task automatic count_rst_high(input int c, output int n);
    n = 0;
    while (O_PLL_RST[c] && n < 50) begin
      n++;
      cycle();
    end
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_pll_rst"}, 32'(O_PLL_RST), 32'h3);
    chk({tag, "_pll_pwrdwn"}, 32'(O_PLL_PWRDWN), 32'h0);
    chk({tag, "_ready"}, 32'(O_READY), 32'h0);
    chk({tag, "_fail"}, 32'(O_FAIL), 32'h0);
    chk({tag, "_all_ready"}, 32'(O_ALL_READY), 32'h0);
    chk({tag, "_loss_cnt"}, 32'(O_LOSS_CNT), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_lock, t_ready, t_rst_lo, t_fail, n, t;
    bit rst_seen;

    rst_n_drv = 1'b0; pd = '0; rs = '0;
    I_LOCKED = '0; I_PWRDWN = '0; I_RESTART = '0; RST = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      ph[c] = POff; left[c] = 0; att[c] = 1; loss[c] = 0;
      pll_ok[c] = 1'b0; delay[c] = 10; since[c] = 0; drop[c] = 1'b0;
    end

    // Reset state.
    repeat (3) cycle();
    reset_vals("por");

    // Bring-up: ch0 locks 10 cycles after its reset falls, ch1 never locks.
    pll_ok[0] = 1'b1;
    rst_n_drv = 1'b1;
    cyc = 0;
    t_lock = -1; t_ready = -1; t_rst_lo = -1; t_fail = -1;
    for (int k = 0; k < 70; k++) begin
      cycle();
      if (t_lock < 0 && I_LOCKED[0]) t_lock = cyc - 1;
      if (t_ready < 0 && O_READY[0]) t_ready = cyc;
      if (t_rst_lo < 0 && !O_PLL_RST[0]) t_rst_lo = cyc;
      if (t_fail < 0 && O_FAIL[1]) t_fail = cyc;
    end
    chk("bringup_rst_width", 32'(t_rst_lo), 32'd4);
    chk("bringup_ready_latency", 32'(t_ready - t_lock), 32'd11);
    chk("nolock_fail_cycle", 32'(t_fail), 32'd60);
    chk("nolock_all_ready", 32'(O_ALL_READY), 32'd0);
    chk("bringup_ready0", 32'(O_READY[0]), 32'd1);

    // Restart the failed channel with a PLL that now locks.
    pll_ok[1] = 1'b1; delay[1] = 6;
    rs[1] = 1'b1;
    cycle();
    chk("restart_fail_clear", 32'(O_FAIL[1]), 32'd0);
    count_rst_high(1, n);
    chk("restart_rst_width", 32'(n), 32'd4);
    for (int k = 0; k < 60 && !O_ALL_READY; k++) cycle();
    chk("restart_all_ready", 32'(O_ALL_READY), 32'd1);

    // Glitch during qualification.
    rs[0] = 1'b1;
    cycle();
    for (int k = 0; k < 60 && ph[0] != PQual; k++) cycle();
    repeat (3) cycle();
    drop[0] = 1'b1;
    cycle();
    drop[0] = 1'b0;
    t_lock = cyc;
    rst_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (O_PLL_RST[0]) rst_seen = 1'b1;
      if (O_READY[0]) break;
    end
    chk("glitch_ready_latency", 32'(cyc - t_lock), 32'd11);
    chk("glitch_no_rst", 32'(rst_seen), 32'd0);

    // Five lock losses on ch0.
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 60 && !O_READY[0]; k++) cycle();
      drop[0] = 1'b1;
      t = cyc;
      cycle();
      for (int k = 0; k < 20 && O_READY[0]; k++) cycle();
      if (i == 0) chk("loss_ready_fall", 32'(cyc - t), 32'd3);
      drop[0] = 1'b0;
      count_rst_high(0, n);
      if (i == 0) chk("loss_rst_width", 32'(n), 32'd4);
      if (i == 0) chk("loss_cnt_first", 32'(O_LOSS_CNT[1:0]), 32'd1);
    end
    chk("loss_cnt_saturated", 32'(O_LOSS_CNT[1:0]), 32'd3);

    // Power-down while locked.
    for (int k = 0; k < 60 && !O_READY[0]; k++) cycle();
    pd[0] = 1'b1;
    cycle();
    chk("pd_pwrdwn", 32'(O_PLL_PWRDWN[0]), 32'd1);
    chk("pd_rst", 32'(O_PLL_RST[0]), 32'd1);
    chk("pd_ready", 32'(O_READY[0]), 32'd0);
    repeat (4) cycle();
    pd[0] = 1'b0;
    cycle();
    chk("pd_release", 32'(O_PLL_PWRDWN[0]), 32'd0);
    count_rst_high(0, n);
    chk("pd_rst_width", 32'(n), 32'd4);
    for (int k = 0; k < 60 && !O_READY[0]; k++) cycle();
    chk("pd_relock", 32'(O_READY[0]), 32'd1);

    // Power-down and restart together: power-down wins.
    pd[1] = 1'b1; rs[1] = 1'b1;
    cycle();
    chk("pd_vs_restart", 32'(O_PLL_PWRDWN[1]), 32'd1);
    cycle();
    pd[1] = 1'b0;
    cycle();

    // Randomized traffic against the model.
    for (int k = 0; k < 500; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if (pd[c]) pd[c] = ($urandom_range(0, 3) != 0);
        else pd[c] = ($urandom_range(0, 59) == 0);
        rs[c] = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 19) == 0) drop[c] = !drop[c];
        if ($urandom_range(0, 99) == 0) pll_ok[c] = !pll_ok[c];
        if (rs[c]) delay[c] = $urandom_range(1, 20);
      end
      rst_n_drv = ($urandom_range(0, 249) != 0);
      cycle();
    end
    rst_n_drv = 1'b1; pd = '0;
    for (int c = 0; c < NCH; c++) begin
      drop[c] = 1'b0; pll_ok[c] = 1'b1; delay[c] = 5;
    end

    // Reset during WAIT_LOCK, then during LOCKED.
    rs = '1;
    cycle();
    for (int k = 0; k < 20 && ph[0] != PWait; k++) cycle();
    rst_n_drv = 1'b0;
    cycle();
    reset_vals("rst_waitlock");
    rst_n_drv = 1'b1;
    for (int k = 0; k < 80 && !O_ALL_READY; k++) cycle();
    chk("relock_all_ready", 32'(O_ALL_READY), 32'd1);
    rst_n_drv = 1'b0;
    cycle();
    reset_vals("rst_locked");
    rst_n_drv = 1'b1;
    repeat (5) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
